// File: rtl/result_streamer.sv
// Drains a latched count of result pairs, packs them P per beat, byte-reverses each beat into network order
// and emits one Avalon-ST packet. Back-to-back beats are separated by an m-cycle fetch phase.
module result_streamer #(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6,
  parameter int PAIR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear_done,
  input  logic [COUNT_WIDTH-1:0] pair_num,
  output logic                   pair_rd_en,
  input  logic [PAIR_WIDTH-1:0]  pair_data,
  output logic [DATA_WIDTH-1:0]  src_data,
  output logic                   src_valid,
  input  logic                   src_ready,
  output logic [EMPTY_WIDTH-1:0] src_empty,
  output logic                   src_sop,
  output logic                   src_eop,
  output logic                   busy,
  output logic                   done
);

  localparam int P   = DATA_WIDTH / PAIR_WIDTH;
  localparam int BPP = PAIR_WIDTH / 8;
  localparam int CW  = $clog2(P) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t                 state, state_nx;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   first;
  logic [CW-1:0]          m_cnt, rd_cnt, cap_cnt;
  logic                   rd_d;
  logic                   idle_like, capture, last_cap, accept;

  function automatic logic [PAIR_WIDTH-1:0] bswap(input logic [PAIR_WIDTH-1:0] x);
    logic [PAIR_WIDTH-1:0] y;
    y = '0;
    for (int b = 0; b < BPP; b++) y[8*b +: 8] = x[PAIR_WIDTH-8-8*b +: 8];
    return y;
  endfunction

  function automatic logic [CW-1:0] lane_count(input logic [COUNT_WIDTH-1:0] n);
    if (n >= COUNT_WIDTH'(P)) return CW'(P);
    return CW'(n);
  endfunction

  assign idle_like = (state == IDLE) || (state == DONE);
  assign capture   = (state == FETCH) && rd_d;
  assign last_cap  = capture && (cap_cnt == m_cnt - 1'b1);
  assign accept    = src_valid && src_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = (pair_num == '0) ? DONE : FETCH;
      FETCH:      if (last_cap) state_nx = SEND;
      SEND:       if (accept) state_nx = (remaining != '0) ? FETCH : DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    pair_rd_en = (state == FETCH) && (rd_cnt < m_cnt);
    busy       = (state == FETCH) || (state == SEND);
  end

  // Each pair lands directly in its byte-reversed slot, so the beat register is the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      first     <= 1'b0;
      m_cnt     <= '0;
      rd_cnt    <= '0;
      cap_cnt   <= '0;
      rd_d      <= 1'b0;
      done      <= 1'b0;
      src_data  <= '0;
      src_valid <= 1'b0;
      src_sop   <= 1'b0;
      src_eop   <= 1'b0;
      src_empty <= '0;
    end else begin
      rd_d <= pair_rd_en;
      if (idle_like && start) begin
        remaining <= pair_num;
        first     <= 1'b1;
        m_cnt     <= lane_count(pair_num);
        rd_cnt    <= '0;
        cap_cnt   <= '0;
        src_data  <= '0;
        done      <= (pair_num == '0);
      end else if (idle_like && clear_done) begin
        done <= 1'b0;
      end
      if (pair_rd_en) rd_cnt <= rd_cnt + 1'b1;
      if (capture) begin
        src_data[DATA_WIDTH-1-PAIR_WIDTH*int'(cap_cnt) -: PAIR_WIDTH] <= bswap(pair_data);
        cap_cnt <= cap_cnt + 1'b1;
      end
      if (last_cap) begin
        remaining <= remaining - COUNT_WIDTH'(m_cnt);
        src_valid <= 1'b1;
        src_sop   <= first;
        src_eop   <= (remaining == COUNT_WIDTH'(m_cnt));
        src_empty <= (remaining == COUNT_WIDTH'(m_cnt)) ?
                     EMPTY_WIDTH'((P - int'(m_cnt)) * BPP) : '0;
      end
      if (state == SEND && accept) begin
        src_valid <= 1'b0;
        src_sop   <= 1'b0;
        src_eop   <= 1'b0;
        src_empty <= '0;
        first     <= 1'b0;
        if (remaining != '0) begin
          m_cnt    <= lane_count(remaining);
          rd_cnt   <= '0;
          cap_cnt  <= '0;
          src_data <= '0;
        end else begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: table-driven packets, hand-written corner cases and
// randomized packets compared against a packet-level reference model.
module tb_result_streamer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         clear_done = 1'b0;
  logic [15:0]  pair_num = '0;
  logic         pair_rd_en;
  logic [31:0]  pair_data = '0;
  logic [511:0] src_data;
  logic         src_valid;
  logic         src_ready = 1'b1;
  logic [5:0]   src_empty;
  logic         src_sop, src_eop, busy, done;

  result_streamer dut (
    .clk(clk), .reset(reset), .start(start), .clear_done(clear_done),
    .pair_num(pair_num), .pair_rd_en(pair_rd_en), .pair_data(pair_data),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_empty(src_empty), .src_sop(src_sop), .src_eop(src_eop),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } beat_t;

  typedef struct {
    int n;
    int beats;
    int last_empty;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_seen, first_valid, start_cyc, done_rises;
  int rd_ptr = 0;
  logic rnd_ready = 1'b0;
  logic [31:0] mem [0:255];
  beat_t got_q[$];
  beat_t exp_q[$];
  beat_t prev;
  logic prev_hold = 1'b0;
  logic exp_done_next = 1'b0;
  logic done_q = 1'b0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Result buffer: one-cycle read latency, pointer restarts when an accepted start arrives.
  always @(posedge clk) begin
    if (reset || (start && !busy)) rd_ptr <= 0;
    else if (pair_rd_en) begin
      pair_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_hold     = 1'b0;
      exp_done_next = 1'b0;
      done_q        = done;
    end else begin
      beat_t cur;
      if (done && !done_q) done_rises++;
      done_q = done;
      if (exp_done_next) begin
        chk("done_after_eop", done, 1);
        exp_done_next = 1'b0;
      end
      if (pair_rd_en) rd_seen++;
      if (prev_hold) begin
        chk("hold_valid", src_valid, 1);
        chk("hold_data", src_data, prev.data);
        chk("hold_ctl", {src_sop, src_eop, src_empty}, {prev.sop, prev.eop, prev.empty});
      end
      cur.data = src_data; cur.sop = src_sop; cur.eop = src_eop; cur.empty = src_empty;
      if (src_valid && first_valid < 0) first_valid = cyc;
      if (src_valid && src_ready) begin
        got_q.push_back(cur);
        if (src_eop) begin
          chk("done_before_eop_accept", done, 0);
          exp_done_next = 1'b1;
        end
        prev_hold = 1'b0;
      end else if (src_valid) begin
        prev_hold = 1'b1;
        prev      = cur;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) src_ready = 1'($urandom_range(0, 1));
  endtask

  // Packet-level reference: split into groups of 16, lanes little-endian in w, whole beat byte-reversed.
  task automatic build_expected(input int n);
    exp_q.delete();
    for (int b = 0; b * 16 < n; b++) begin
      beat_t e;
      logic [511:0] w;
      int m;
      m = (n - 16 * b < 16) ? n - 16 * b : 16;
      w = '0;
      for (int k = 0; k < m; k++) w[32*k +: 32] = mem[16*b + k];
      for (int i = 0; i < 64; i++) e.data[8*i +: 8] = w[8*(63-i) +: 8];
      e.sop   = (b == 0);
      e.eop   = (16 * (b + 1) >= n);
      e.empty = e.eop ? 6'((16 - m) * 4) : 6'd0;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_packet(input int n, input bit rnd_data, input bit rnd_rdy,
                            input int hold, input bit restart);
    int held;
    bit released;
    for (int i = 0; i < 256; i++) mem[i] = rnd_data ? $urandom : 32'(i + 1);
    build_expected(n);
    got_q.delete();
    rd_seen = 0; first_valid = -1; done_rises = 0;
    held = 0; released = 1'b0;
    rnd_ready = rnd_rdy;
    if (!rnd_rdy) src_ready = (hold == 0);
    pair_num = 16'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    start_cyc = cyc;
    if (n == 0) begin
      chk("zero_done_next_cycle", done, 1);
      chk("zero_busy", busy, 0);
    end
    for (int i = 0; i < n * 40 + 200 && !done; i++) begin
      step();
      start = 1'b0;
      if (restart && i == 3) begin
        chk("restart_in_fetch", busy && !src_valid, 1);
        pair_num = 16'd5;
        start = 1'b1;
      end
      if (hold > 0 && !released && src_valid) begin
        held++;
        if (held > hold) begin
          chk("hold_no_extra_rd", rd_seen, 16);
          src_ready = 1'b1;
          released  = 1'b1;
        end
      end
    end
    start = 1'b0;
    if (!done) chk("packet_timeout", 0, 1);
    rnd_ready = 1'b0;
    src_ready = 1'b1;
    step(); step();
    chk("beat_count", got_q.size(), exp_q.size());
    for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
      chk("beat_data", got_q[b].data, exp_q[b].data);
      chk("beat_ctl", {got_q[b].sop, got_q[b].eop, got_q[b].empty},
          {exp_q[b].sop, exp_q[b].eop, exp_q[b].empty});
    end
    chk("rd_strobes", rd_seen, n);
    chk("done_rises", done_rises, 1);
    if (n > 0) chk("first_beat_latency", first_valid - start_cyc + 1, (n < 16 ? n : 16) + 2);
    else       chk("zero_no_valid", first_valid, -1);
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    chk("clear_done", done, 0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{16, 1, 0};  vecs[1] = '{20, 2, 48}; vecs[2] = '{0, 0, 0};
    vecs[3] = '{40, 3, 32}; vecs[4] = '{1, 1, 60};  vecs[5] = '{15, 1, 4};
    vecs[6] = '{17, 2, 60}; vecs[7] = '{32, 2, 0};  vecs[8] = '{33, 3, 60};

    #2;
    chk("reset_outputs", {pair_rd_en, src_valid, src_sop, src_eop, src_empty, busy, done}, '0);
    chk("reset_data", src_data, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_packet(vecs[i].n, 1'b0, 1'b0, 0, 1'b0);
      chk("tbl_beats", got_q.size(), vecs[i].beats);
      if (got_q.size() > 0) chk("tbl_last_empty", got_q[got_q.size()-1].empty, vecs[i].last_empty);
    end

    // Single full beat with pairs 1..16.
    run_packet(16, 1'b0, 1'b0, 0, 1'b0);
    if (got_q.size() > 0) chk("full_beat_top_word", got_q[0].data[511:480], 32'h01000000);
    else chk("full_beat_present", 0, 1);

    // Backpressure on the first beat of a 40-pair packet.
    run_packet(40, 1'b1, 1'b0, 5, 1'b0);

    // Second start during FETCH is ignored.
    run_packet(20, 1'b1, 1'b0, 0, 1'b1);

    // Reset while the first beat is waiting.
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
    src_ready = 1'b0;
    pair_num = 16'd20;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && !src_valid; i++) step();
    chk("pre_reset_valid", src_valid, 1);
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {pair_rd_en, src_valid, src_sop, src_eop, src_empty, busy, done}, '0);
    chk("midreset_data", src_data, '0);
    step();
    reset = 1'b0;
    step();
    run_packet(16, 1'b0, 1'b0, 0, 1'b0);

    // Randomized packets with random backpressure.
    for (int r = 0; r < 6; r++) run_packet(int'($urandom_range(1, 100)), 1'b1, 1'b1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_streamer.md
# result_streamer

Transmit side of the accelerator's Avalon-ST port. On a start pulse it drains a latched count of 32-bit SNP-pair results from the engine's result buffer. It packs the pairs 16 per beat into 512-bit beats, byte-reverses each beat into network order, and emits them as one packet on the `src_*` source interface. The block sits between the epistasis engine's result read port and the streaming DMA, and replaces the tied-off source port.

## Interface

**Parameters**
- `DATA_WIDTH`, 512: stream width in bits; multiple of `PAIR_WIDTH`.
- `EMPTY_WIDTH`, 6: log2(`DATA_WIDTH`/8).
- `PAIR_WIDTH`, 32: width of one result pair.
- `COUNT_WIDTH`, 16: width of the pair count.

**Ports**
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse that starts a packet.
- `clear_done` in 1: one-cycle pulse that clears `done`.
- `pair_num` in `COUNT_WIDTH`: number of pairs available; sampled only on `start`.
- `pair_rd_en` out 1: read strobe to the result buffer.
- `pair_data` in `PAIR_WIDTH`: result pair, valid the cycle after `pair_rd_en`.
- `src_data` out `DATA_WIDTH`: beat data, network byte order.
- `src_valid` out 1: beat valid.
- `src_ready` in 1: sink accepts the beat.
- `src_empty` out `EMPTY_WIDTH`: unused bytes in the beat; meaningful only with `src_eop`.
- `src_sop` out 1: first beat of the packet.
- `src_eop` out 1: last beat of the packet.
- `busy` out 1: a packet is in progress.
- `done` out 1: sticky; packet complete.

## Operation

- Local constant: P = `DATA_WIDTH`/`PAIR_WIDTH` = 16.
- **FSM states:** IDLE, FETCH, SEND, DONE.

**IDLE / DONE**
- On `start`: latch `remaining` = `pair_num`, set `first` = 1, clear `done`, then:
  - if `pair_num` = 0, go to DONE; no beat is emitted.
  - otherwise go to FETCH.
- `start` is ignored in FETCH and SEND.
- `clear_done` clears `done` in IDLE and DONE and is ignored otherwise. `start` and `clear_done` in the same cycle: `start` wins.

**FETCH**
- m = min(P, `remaining`).
- Assert `pair_rd_en` for exactly m consecutive cycles.
- Capture `pair_data` one cycle after each strobe into lane k = 0..m-1 of the internal word w, at bits [32k+31:32k]. Unused lanes are zero.
- After the m-th capture go to SEND; `remaining` -= m.

**SEND**
- `src_data` is the byte reversal of w: byte i of `src_data` = byte (63-i) of w.
- `src_sop` = `first`.
- `src_eop` = (`remaining` == 0).
- `src_empty` = (P - m)*4 when `src_eop` is 1, else 0.
- On `src_valid` && `src_ready`: clear `first`, then go to FETCH if `remaining` > 0, else go to DONE and set `done`.

**Status and arithmetic**
- `busy` = 1 in FETCH and SEND.
- `remaining` is `COUNT_WIDTH` wide with no wrap. The maximum packet is 65535 pairs = 4096 beats, last beat `src_empty` = 4.

## Timing

- **Reset values:** state IDLE, `pair_rd_en`=0, `src_valid`=0, `src_sop`=0, `src_eop`=0, `src_empty`=0, `src_data`=0, `busy`=0, `done`=0.
- **First beat latency:** with `start` sampled at edge 0, `pair_rd_en` is high in cycles 1..m and `pair_data` is captured in cycles 2..m+1. `src_valid` rises in cycle m+2, so a full beat appears 18 cycles after `start`.
- **Handshake:** `src_data`, `src_sop`, `src_eop` and `src_empty` are all registered outputs. They stay stable while `src_valid`=1 and `src_ready`=0.
  - `src_valid` never drops without acceptance.
  - The next beat's FETCH begins the cycle after acceptance. There is no overlap, so peak throughput is one beat per m+2 cycles.
- **Completion:** `done` rises the cycle after the last beat is accepted. In the zero-count case it rises the cycle after `start`.
- **Reset mid-packet:** everything returns to reset values immediately. The packet is truncated with no `eop`; downstream logic is reset together with this block.
- **Source outputs outside SEND:** `src_valid` is 0 in IDLE, FETCH and DONE.

## Test plan

- **Single full beat:** `pair_num`=16 with pairs 0x00000001..0x00000010, `src_ready`=1 → one beat with `src_sop`=`src_eop`=1 and `src_empty`=0. `src_data`[511:480]=0x01000000. `src_valid` rises 18 cycles after `start`.
- **Partial last beat:** `pair_num`=20 → beat 1 has `src_sop`=1, `src_eop`=0. Beat 2 has `src_sop`=0, `src_eop`=1, `src_empty`=48. Unused lanes are zero. `pair_rd_en` totals 20 cycles.
- **Zero count:** `pair_num`=0 → `pair_rd_en` and `src_valid` never assert; `done`=1 one cycle after `start`; `clear_done` → `done`=0.
- **Backpressure:** `src_ready` low for 5 cycles during beat 1 of a 40-pair packet → beat held stable, no extra `pair_rd_en`. Three beats total, last `src_empty`=32.
- **Start while busy:** a second `start` during FETCH of a 20-pair packet → ignored; still exactly two beats and one `done`.
- **Reset mid-packet:** `reset` asserted in SEND of beat 1 → all outputs 0 in the same cycle. A subsequent `start` with 16 pairs produces a clean single-beat packet.
